// File: rtl/adder_rr_scheduler.sv
// Round-robin front end that shares one carry-prefix tree among NREQ requesters.
// Issues g/p for one granted request per cycle and rebuilds the sum from the tree's carries.
module adder_rr_scheduler #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [N-1:0]        tree_g,
    output logic [N-1:0]        tree_p,
    output logic                tree_in_valid,
    input  logic [N-1:0]        tree_c,
    input  logic                tree_out_valid,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [N-1:0]        res_sum,
    output logic                res_cout,
    output logic                busy,
    output logic                err
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            issue;
    logic            found;
    logic [IDW-1:0]  idx;
    int              sum_idx;
    logic [N-1:0]    a_sel, b_sel;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found   = 1'b0;
        idx     = '0;
        sum_idx = 0;
        for (int off = 1; off <= NREQ; off++) begin
            sum_idx = int'(ptr_q) + off;
            if (sum_idx >= NREQ) sum_idx = sum_idx - NREQ;
            idx = IDW'(sum_idx);
            if (en && !found && req_valid[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    assign issue         = |gnt;
    assign req_ready     = gnt;
    assign tree_in_valid = issue;
    assign a_sel         = req_a[int'(gnt_id)*N +: N];
    assign b_sel         = req_b[int'(gnt_id)*N +: N];
    assign tree_g        = issue ? (a_sel & b_sel) : '0;
    assign tree_p        = issue ? (a_sel ^ b_sel) : '0;
    assign ptr_d         = issue ? gnt_id : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= IDW'(NREQ-1);
        else     ptr_q <= ptr_d;
    end

    logic           tag_v;
    logic [IDW-1:0] tag_id;
    logic [N-1:0]   tag_p;

    generate
        if (LAT == 1) begin : g_pipe
            logic           tag_v_q;
            logic [IDW-1:0] tag_id_q;
            logic [N-1:0]   tag_p_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_v_q  <= 1'b0;
                    tag_id_q <= '0;
                    tag_p_q  <= '0;
                end else begin
                    tag_v_q  <= issue;
                    tag_id_q <= gnt_id;
                    tag_p_q  <= tree_p;
                end
            end
            assign tag_v  = tag_v_q;
            assign tag_id = tag_id_q;
            assign tag_p  = tag_p_q;
            assign busy   = tag_v_q;
        end else begin : g_wire
            assign tag_v  = issue;
            assign tag_id = gnt_id;
            assign tag_p  = tree_p;
            assign busy   = 1'b0;
        end
    endgenerate

    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err_q <= 1'b0;
        else if (tree_out_valid != tag_v) err_q <= 1'b1;
    end
    assign err = err_q;

    // Carry-in is zero, so bit 0 of the sum is just p[0].
    logic res_v;
    assign res_v     = tag_v & ~rst;
    assign res_valid = res_v;
    assign res_id    = res_v ? tag_id : '0;
    assign res_sum   = res_v ? (tag_p ^ {tree_c[N-2:0], 1'b0}) : '0;
    assign res_cout  = res_v & tree_c[N-1];

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: behavioural prefix tree, round-robin reference model, result scoreboard.
module tb_adder_rr_scheduler;
    localparam int N = 8;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ-1:0] req_ready;
    logic [N-1:0]    tree_g, tree_p, tree_c;
    logic            tree_in_valid, tree_out_valid;
    logic            res_valid, res_cout, busy, err;
    logic [1:0]      res_id;
    logic [N-1:0]    res_sum;

    int n_chk = 0;
    int n_fail = 0;
    logic force_tov = 1'b0;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.N(N), .NREQ(NREQ), .LAT(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .tree_g(tree_g), .tree_p(tree_p), .tree_in_valid(tree_in_valid),
        .tree_c(tree_c), .tree_out_valid(tree_out_valid), .res_valid(res_valid), .res_id(res_id),
        .res_sum(res_sum), .res_cout(res_cout), .busy(busy), .err(err)
    );

    function automatic logic [N-1:0] carries(input logic [N-1:0] g, input logic [N-1:0] p);
        logic [N-1:0] c;
        logic prev;
        prev = 1'b0;
        for (int j = 0; j < N; j++) begin
            c[j] = g[j] | (p[j] & prev);
            prev = c[j];
        end
        return c;
    endfunction

    // One-cycle behavioural tree
    logic [N-1:0] tc_q;
    logic         tov_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q  <= '0;
            tov_q <= 1'b0;
        end else begin
            tc_q  <= carries(tree_g, tree_p);
            tov_q <= tree_in_valid;
        end
    end
    assign tree_c = tc_q;
    assign tree_out_valid = tov_q | force_tov;

    // Second instance, combinational tree
    logic [NREQ-1:0]   v0, rdy0;
    logic [NREQ*N-1:0] a0, b0;
    logic [N-1:0]      g0, p0, c0, sum0;
    logic              tiv0, rv0, cout0, busy0, err0;
    logic [1:0]        id0;
    assign c0 = carries(g0, p0);

    adder_rr_scheduler #(.N(N), .NREQ(NREQ), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .en(1'b1), .req_valid(v0), .req_a(a0), .req_b(b0),
        .req_ready(rdy0), .tree_g(g0), .tree_p(p0), .tree_in_valid(tiv0),
        .tree_c(c0), .tree_out_valid(tiv0), .res_valid(rv0), .res_id(id0),
        .res_sum(sum0), .res_cout(cout0), .busy(busy0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference round-robin model
    logic [1:0]      m_ptr;
    logic [NREQ-1:0] m_gnt;
    logic [1:0]      m_id;
    always_comb begin
        m_gnt = '0;
        m_id  = '0;
        if (en) begin
            for (int off = NREQ; off >= 1; off--) begin
                if (req_valid[(int'(m_ptr) + off) % NREQ]) begin
                    m_gnt = '0;
                    m_gnt[(int'(m_ptr) + off) % NREQ] = 1'b1;
                    m_id = 2'((int'(m_ptr) + off) % NREQ);
                end
            end
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst)        m_ptr <= 2'd3;
        else if (|m_gnt) m_ptr <= m_id;
    end

    typedef struct packed { logic [1:0] id; logic [8:0] s; } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (sbq.size() == 0) chk("sb_unexpected_result", 1, 0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_id", 32'(res_id), 32'(e.id));
                    chk("sb_sum", 32'(res_sum), 32'(e.s[7:0]));
                    chk("sb_cout", 32'(res_cout), 32'(e.s[8]));
                end
            end
            chk("sb_grant", 32'(req_ready), 32'(m_gnt));
            chk("sb_tiv", 32'(tree_in_valid), 32'(|m_gnt));
            if (|m_gnt) begin
                logic [7:0] a, b;
                exp_t e;
                a = req_a[int'(m_id)*N +: N];
                b = req_b[int'(m_id)*N +: N];
                e.id = m_id;
                e.s  = {1'b0, a} + {1'b0, b};
                sbq.push_back(e);
                chk("sb_tree_g", 32'(tree_g), 32'(a & b));
                chk("sb_tree_p", 32'(tree_p), 32'(a ^ b));
            end else begin
                chk("sb_tree_idle", 32'({tree_g, tree_p}), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        v0 = '0; a0 = '0; b0 = '0;
        step(); step();
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy_err", 32'({busy, err}), 0);
        chk("rst_res_sum", 32'({res_id, res_sum, res_cout}), 0);
        rst = 1'b0;

        // Single request
        req_valid = 4'b0001; set_op(0, 8'h7F, 8'h01);
        @(negedge clk); chk("t1_ready", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 1);
        chk("t1_id", 32'(res_id), 0);
        chk("t1_sum", 32'(res_sum), 32'h80);
        chk("t1_cout", 32'(res_cout), 0);

        // Overflow
        step(); req_valid = 4'b0100; set_op(2, 8'hFF, 8'h01);
        @(negedge clk); chk("t2_ready", 32'(req_ready), 32'h4);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t2_id", 32'(res_id), 2);
        chk("t2_sum", 32'(res_sum), 0);
        chk("t2_cout", 32'(res_cout), 1);

        // All four valid after reset
        step(); rst = 1'b1; step(); rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NREQ; k++)
                set_op(k, 8'(i*37 + k*53 + 11), 8'(i*91 + k*29 + 200));
            @(negedge clk);
            chk("t3_grant", 32'(req_ready), 32'(1 << (i % 4)));
            if (i > 0) chk("t3_res_id", 32'(res_id), 32'((i - 1) % 4));
            step();
        end
        req_valid = '0;
        @(negedge clk); chk("t3_last_id", 32'(res_id), 3);

        // Intermittent requesters, then en low
        step(); req_valid = 4'b1010;
        set_op(1, 8'h12, 8'h34); set_op(3, 8'hC8, 8'h64);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_grant", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
            step();
        end
        en = 1'b0;
        @(negedge clk);
        chk("t4_en0_ready", 32'({req_ready, tree_in_valid}), 0);
        chk("t4_en0_pending", 32'({res_valid, res_id}), 32'h7);
        step();
        @(negedge clk);
        chk("t4_en0_ready2", 32'({req_ready, tree_in_valid}), 0);
        chk("t4_en0_drained", 32'(res_valid), 0);
        step(); en = 1'b1;
        @(negedge clk); chk("t4_resume", 32'(req_ready), 32'h2);
        step(); req_valid = '0;
        step();

        // Asynchronous reset with an operation in flight
        req_valid = 4'b0100; set_op(2, 8'h55, 8'h0A);
        @(negedge clk); chk("t5_ready", 32'(req_ready), 32'h4);
        step(); req_valid = '0;
        #2; rst = 1'b1; sbq.delete();
        #1;
        chk("t5_rst_valid", 32'(res_valid), 0);
        chk("t5_rst_busy_err", 32'({busy, err}), 0);
        step(); rst = 1'b0;
        @(negedge clk); chk("t5_no_stale", 32'(res_valid), 0);
        step(); req_valid = 4'b1111;
        @(negedge clk); chk("t5_first_grant", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        step(); step();

        // Tree valid disagreeing with the tag pipe
        chk("t6_err_clean", 32'(err), 0);
        force_tov = 1'b1;
        step(); force_tov = 1'b0;
        @(negedge clk); chk("t6_err_set", 32'(err), 1);
        step(); step(); step();
        @(negedge clk); chk("t6_err_sticky", 32'(err), 1);
        step(); rst = 1'b1; #1;
        chk("t6_err_cleared", 32'(err), 0);
        step(); rst = 1'b0;

        // Combinational (LAT=0) build
        v0 = 4'b0010; a0[1*N +: N] = 8'h3C; b0[1*N +: N] = 8'h0F;
        @(negedge clk);
        chk("l0_valid", 32'(rv0), 1);
        chk("l0_id", 32'(id0), 1);
        chk("l0_sum", 32'({cout0, sum0}), 32'h04B);
        step(); v0 = 4'b1000; a0[3*N +: N] = 8'hF0; b0[3*N +: N] = 8'h20;
        @(negedge clk);
        chk("l0_id2", 32'(id0), 3);
        chk("l0_sum2", 32'({cout0, sum0}), 32'h110);
        chk("l0_busy_err", 32'({busy0, err0}), 0);
        step(); v0 = '0;
        @(negedge clk); chk("l0_idle", 32'({rv0, sum0}), 0);

        step(); step();
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one prefix_tree carry network, whether pipelined or combinational, among NREQ operand requesters using round-robin arbitration.
- Each cycle, at most one requester's operands are issued to the tree, as g=a&b and p=a^b.
- The block tracks each issued operation's requester ID and propagate vector through a LAT-deep tag pipe, forms the sum from the returned carries, and routes the result back with its ID.
- The block sits between the requester ports and the shared tree instance.

Parameters:
- N, 32, operand width; must match the tree.
- NREQ, 4, number of requesters; must be at least 2.
- LAT, 1, tree latency in cycles; 0 or 1, and must equal the tree's PIPE setting.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  when low, no new grants are issued; in-flight operations still drain.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*N  operand A; requester i occupies bits [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; the operation transfers when req_valid[i] and req_ready[i] are both high.
- tree_g  out  N  generate vector to the tree.
- tree_p  out  N  propagate vector to the tree.
- tree_in_valid  out  1  issue strobe to the tree.
- tree_c  in  N  carry vector from the tree.
- tree_out_valid  in  1  valid from the tree.
- res_valid  out  1  result strobe.
- res_id  out  IDW  ID of the requester that owns the result.
- res_sum  out  N  sum a+b, modulo 2^N.
- res_cout  out  1  carry out.
- busy  out  1  high while any operation is in flight.
- err  out  1  sticky flag: tree_out_valid disagreed with the tag pipe.

Behaviour:
- Reset, asynchronous: all of the following are cleared immediately:
  - the round-robin pointer, which is set to NREQ-1 so requester 0 has first priority;
  - the tag pipe valid, ID and p registers;
  - err.
  - res_* outputs read 0 during reset.
- Arbitration, combinational in the same cycle:
  - When en=1, the grant goes to the first requester with req_valid high, searching from ptr+1 upward with wrap-around.
  - When en=0 or no requester is valid, req_ready is all zero.
  - req_ready is never asserted to a requester whose req_valid is low.
- Pointer update:
  - On a handshake with requester k, ptr becomes k on the next clock edge.
  - With no handshake, ptr holds.
- Issue:
  - tree_in_valid equals the OR of the handshake bits.
  - tree_g = a&b and tree_p = a^b of the granted requester.
  - Both vectors are 0 when nothing is issued.
- Tag pipe, for LAT=1:
  - On each edge, tag_v, tag_id and tag_p load the issue valid, the granted ID and tree_p.
  - tag_v is written every cycle, so a bubble is tracked as tag_v=0.
- Tag pipe, for LAT=0:
  - The tag pipe is wires only.
  - The result is combinational from the requester inputs.
- Result, combinational from the tag pipe and tree_c:
  - res_valid = tag_v.
  - res_id = tag_id.
  - res_sum[0] = tag_p[0].
  - res_sum[j] = tag_p[j] ^ tree_c[j-1], for j=1..N-1.
  - res_cout = tree_c[N-1].
  - Carry-in is fixed at 0.
  - When tag_v=0, res_sum, res_cout and res_id are driven to 0.
- Throughput:
  - One operation per cycle, back-to-back issue from the same or different requesters.
  - Results return in issue order.
  - There is no result back-pressure: consumers must accept res_valid on the cycle it is asserted.
- Latency: the result appears LAT cycles after the handshake cycle.
- busy = tag_v, for LAT=1. For LAT=0, busy = 0.
- err is set on any cycle where tree_out_valid != tag_v, and is cleared only by rst.
- en deasserted mid-stream:
  - The current cycle issues nothing.
  - The operation already in the tag pipe still produces its result.
- Reset mid-operation: in-flight results are discarded and no res_valid is produced for them.
- Simultaneous requests from all NREQ requesters: strict rotation, with each requester served exactly once every NREQ cycles.
- A requester that drops req_valid before being granted is skipped without penalty.

Test Plan:
- Single request, with N=8, NREQ=4, LAT=1:
  - Stimulus: req0 issues a=0x7F, b=0x01.
  - Response: req_ready[0] the same cycle; the next cycle res_valid=1, id=0, sum=0x80, cout=0.
- Overflow, with N=8:
  - Stimulus: req2 issues a=0xFF, b=0x01.
  - Response: sum=0x00, cout=1, id=2, one cycle after grant.
- All four requesters held valid for 8 cycles after reset, with distinct operands:
  - Grant order: 0,1,2,3,0,1,2,3.
  - Results: each sum correct, with ids in the same order and delayed by one cycle.
- Intermittent requests:
  - Stimulus: only req1 and req3 valid.
  - Response: grants alternate 1,3,1,3.
  - Stimulus: en=0 for 2 cycles.
  - Response: no req_ready and no tree_in_valid; the pending result from the cycle before en fell still appears.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously, between clock edges, one cycle after a grant.
  - Response: res_valid, busy and err drop to 0 immediately; no stale result after rst is released; the first grant after reset goes to req0.
- Tree mismatch:
  - Stimulus: force tree_out_valid=1 while tag_v=0.
  - Response: err=1 and stays set until rst.
  - Stimulus: LAT=0 build.
  - Response: res_valid in the same cycle as the handshake, with the correct sum.
